lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//   Load/store requester for the word-wide data memory: takes one load/store
//   per request from the execute stage, drives the memory's WRn/RDn/addr/DIN
//   pins and samples DOUT. Handles RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW: byte-lane
//   extraction with sign/zero extension, and read-modify-write for sub-word stores.
// PARAMETERS
//   ADDR_W  32  width of the byte address from the core
//   MEM_AW   5  word-address width of the data memory (2**MEM_AW words)
// PORTS
//   CLK         in   1       clock, all state updates on rising edge
//   RST         in   1       asynchronous reset, active-high
//   req_valid   in   1       request present
//   req_ready   out  1       block can accept a request (high only in IDLE)
//   req_we      in   1       1 = store, 0 = load
//   req_funct3  in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//   req_addr    in   ADDR_W  byte address
//   req_wdata   in   32      store data; low byte/half used for SB/SH
//   rsp_valid   out  1       one-cycle completion pulse
//   rsp_rdata   out  32      extended load data; 0 for stores and errors
//   rsp_err     out  1       qualified by rsp_valid: misaligned or illegal op
//   mem_addr    out  MEM_AW  word address to memory (= req_addr[MEM_AW+1:2])
//   mem_din     out  32      write data to memory
//   mem_dout    in   32      read data from memory, valid same cycle as mem_RDn
//   mem_WRn     out  1       memory write enable, driven with `WriteEnable when active
//   mem_RDn     out  1       memory read enable, driven with `ReadEnable when active
// BEHAVIOUR
//   Reset: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_din=0,
//     mem_WRn/mem_RDn at their inactive levels. Reset mid-operation aborts the access;
//     a WRITE cut by reset must not write (enables drop as RST rises).
//   FSM states: IDLE, READ, WRITE, RESP. Enables decoded from state register only.
//   IDLE: req_ready=1. Accept on rising edge with req_valid=1; latch we, funct3, addr
//     byte offset, wdata; load mem_addr. Next state:
//     - error (H/HU with addr[0]!=0, W with addr[1:0]!=0, funct3 not listed,
//       store with BU/HU) -> RESP, rsp_err=1, no memory access
//     - load -> READ;  SW -> WRITE (mem_din=wdata);  SB/SH -> READ
//   READ (1 cycle): mem_RDn active; mem_dout captured at end of cycle.
//     load -> RESP with rsp_rdata = lane selected by addr[1:0]; B/H sign-extended,
//     BU/HU zero-extended. SB/SH -> WRITE with mem_din = captured word with the
//     addressed byte/half replaced by wdata[7:0]/[15:0], other lanes unchanged.
//   WRITE (1 cycle): mem_WRn active, memory writes on the closing edge -> RESP.
//   RESP (1 cycle): rsp_valid=1, rsp_rdata/rsp_err valid -> IDLE. req_ready=0.
//   Never mem_WRn and mem_RDn active together. Lanes little-endian:
//     byte k = bits[8k+7:8k]; half h = bits[16h+15:16h].
//   Latency, accept edge = T: error rsp_valid in cycle T+1; load/SW in T+2;
//     SB/SH in T+3. Throughput: no new request until back in IDLE.
//   Address bits above MEM_AW+1 ignored (wrap); no range error.
//   rsp_rdata/rsp_err hold last value after rsp_valid drops until next RESP.
// TESTING
//   1 SW addr 0x08 data 0xDEADBEEF -> mem_WRn active one cycle, mem_addr=2,
//     mem_din=0xDEADBEEF; rsp_valid at T+2, rsp_err=0
//   2 word@2=0xDEADBEEF: LB 0x0B -> 0xFFFFFFDE; LBU 0x0B -> 0x000000DE;
//     LH 0x08 -> 0xFFFFBEEF; LHU 0x0A -> 0x0000DEAD; LW 0x08 -> 0xDEADBEEF
//   3 word@2=0xDEADBEEF: SB 0x09 data 0x12 -> READ then WRITE, memory word
//     0xDEAD12EF, rsp_valid at T+3
//   4 LW 0x06, LH 0x05, funct3 011 -> rsp_err=1 at T+1, no mem enable ever active
//   5 RST pulsed during WRITE of SH -> memory word unchanged, outputs at reset
//     values, req_ready=1 after release
//   6 addr 0x80 with MEM_AW=5 -> mem_addr=0 (wrap); back-to-back requests
//     held on req_valid accepted only when req_ready=1

Source files
------------

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store requester for the word-wide data memory
// Byte/half lanes are extracted from and merged into whole words; sub-word stores use read-modify-write.
`ifndef WriteEnable
`define WriteEnable 1'b0
`endif
`ifndef ReadEnable
`define ReadEnable 1'b0
`endif

module lsu_mem_master #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              mem_WRn,
  output logic              mem_RDn
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic              unused_addr_bits;

  // Upper address bits wrap silently onto the small memory.
  assign unused_addr_bits = ^req_addr[ADDR_W-1:MEM_AW+2];

  always_comb begin
    req_err = 1'b1;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = (req_addr[1:0] != 2'b00);
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    load_byte = mem_dout[{off_q, 3'b000} +: 8];
    load_half = mem_dout[{off_q[1], 4'b0000} +: 16];
    load_val  = mem_dout;
    if (funct3_q[1:0] == 2'b00) begin
      load_val = {{24{load_byte[7] & ~funct3_q[2]}}, load_byte};
    end else if (funct3_q[1:0] == 2'b01) begin
      load_val = {{16{load_half[15] & ~funct3_q[2]}}, load_half};
    end
    merged = mem_dout;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata[15:0];
          mem_addr_d = req_addr[MEM_AW+1:2];
          if (req_err) begin
            state_d = RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else if (req_we && req_funct3 == 3'b010) begin
            state_d   = WRITE;
            mem_din_d = req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d   = WRITE;
          mem_din_d = merged;
        end else begin
          state_d = RESP;
          rdata_d = load_val;
          err_d   = 1'b0;
        end
      end
      WRITE: begin
        state_d = RESP;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      wdata_q    <= 16'h0;
      mem_addr_q <= '0;
      mem_din_q  <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Enables come straight from the state register so reset drops them immediately.
  assign mem_RDn   = (state_q == READ)  ? `ReadEnable  : ~`ReadEnable;
  assign mem_WRn   = (state_q == WRITE) ? `WriteEnable : ~`WriteEnable;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - randomized bench for lsu_mem_master with a word-array reference model
module tb_lsu_mem_master;
  localparam int ADDR_W = 32;
  localparam int MEM_AW = 5;

  logic              CLK, RST;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_din, mem_dout;
  logic              mem_WRn, mem_RDn;

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  int n_checks = 0;
  int n_errors = 0;

  lsu_mem_master #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_WRn(mem_WRn), .mem_RDn(mem_RDn)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) if (mem_WRn == 1'b0) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outcome from the instruction semantics alone; updates ref_mem for stores.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int lat, output int rd_n, output int wr_n);
    longint size, off, word, val, mask;
    int idx;
    logic legal;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((addr % size) != 0);
    idx   = int'(addr / 4) % 32;
    off   = addr % 4;
    word  = longint'(ref_mem[idx]);
    rdata = 32'h0;
    if (err) begin
      lat = 1; rd_n = 0; wr_n = 0;
    end else if (!we) begin
      val = (word >> (8 * off)) % (64'd1 << (8 * size));
      if (f3 < 3'd4 && size < 4 && val >= (64'd1 << (8 * size - 1))) val = val - (64'd1 << (8 * size));
      rdata = val[31:0];
      lat = 2; rd_n = 1; wr_n = 0;
    end else begin
      mask = ((64'd1 << (8 * size)) - 1) << (8 * off);
      val  = (word & ~mask) | ((longint'(wdata) << (8 * off)) & mask);
      ref_mem[idx] = val[31:0];
      lat  = (size == 4) ? 2 : 3;
      rd_n = (size == 4) ? 0 : 1;
      wr_n = 1;
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
    logic e_err;
    logic [31:0] e_rdata, o_rdata;
    int e_lat, e_rd, e_wr, lat, rd_n, wr_n, bad_n;
    logic o_err;
    model(we, f3, addr, wdata, e_err, e_rdata, e_lat, e_rd, e_wr);
    @(negedge CLK);
    for (int w = 0; w < 10 && !req_ready; w++) @(negedge CLK);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    lat = 99; rd_n = 0; wr_n = 0; bad_n = 0; o_err = 1'bx; o_rdata = 'x;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1) req_valid = 1'b0;
      if (!mem_RDn) rd_n++;
      if (!mem_WRn) begin
        wr_n++;
        if (mem_din !== ref_mem[addr[6:2]]) bad_n++;
      end
      if (!mem_RDn && !mem_WRn) bad_n++;
      if ((!mem_RDn || !mem_WRn) && mem_addr !== addr[6:2]) bad_n++;
      if (rsp_valid) begin
        lat = k; o_err = rsp_err; o_rdata = rsp_rdata;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_err"}, 32'(o_err), 32'(e_err));
    check({tag, "_rdata"}, o_rdata, e_rdata);
    check({tag, "_rd_cycles"}, 32'(rd_n), 32'(e_rd));
    check({tag, "_wr_cycles"}, 32'(wr_n), 32'(e_wr));
    check({tag, "_bus"}, 32'(bad_n), 32'd0);
    check({tag, "_memword"}, mem[addr[6:2]], ref_mem[addr[6:2]]);
  endtask

  initial begin
    int rsp_mask, viol;
    logic [31:0] keep;
    for (int i = 0; i < 32; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge CLK);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", mem_din, 32'h0);
    check("rst_enables", {30'd0, mem_WRn, mem_RDn}, 32'd3);
    RST = 1'b0;

    run_req(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, "sw08");
    run_req(1'b0, 3'b000, 32'h0B, 32'h0, "lb0b");
    run_req(1'b0, 3'b100, 32'h0B, 32'h0, "lbu0b");
    run_req(1'b0, 3'b001, 32'h08, 32'h0, "lh08");
    run_req(1'b0, 3'b101, 32'h0A, 32'h0, "lhu0a");
    run_req(1'b0, 3'b010, 32'h08, 32'h0, "lw08");
    run_req(1'b1, 3'b000, 32'h09, 32'h12, "sb09");
    check("sb09_word", mem[2], 32'hDEAD12EF);
    run_req(1'b0, 3'b010, 32'h06, 32'h0, "lw06_mis");
    run_req(1'b0, 3'b001, 32'h05, 32'h0, "lh05_mis");
    run_req(1'b0, 3'b011, 32'h08, 32'h0, "f3_011");
    run_req(1'b1, 3'b100, 32'h08, 32'h55, "sbu_ill");

    for (int i = 0; i < 80; i++) begin
      run_req(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
              $urandom, "rand");
    end

    // Reset during the WRITE phase of an SH must leave memory untouched.
    run_req(1'b1, 3'b010, 32'h10, 32'h11223344, "sw10");
    keep = mem[4];
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'hABCD;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 1) req_valid = 1'b0;
      if (!mem_WRn) break;
    end
    check("rstmid_in_write", 32'(mem_WRn), 32'd0);
    RST = 1'b1;
    #1;
    check("rstmid_wr_drop", 32'(mem_WRn), 32'd1);
    @(negedge CLK);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_rdata", rsp_rdata, 32'h0);
    check("rstmid_err", 32'(rsp_err), 32'd0);
    check("rstmid_addr", 32'(mem_addr), 32'd0);
    check("rstmid_din", mem_din, 32'h0);
    check("rstmid_enables", {30'd0, mem_WRn, mem_RDn}, 32'd3);
    RST = 1'b0;
    @(negedge CLK);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_word", mem[4], keep);
    check("rstmid_ref", mem[4], ref_mem[4]);

    // Held request at a wrapping address: accepts only from IDLE, one response every three cycles.
    rsp_mask = 0; viol = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80; req_wdata = 32'h0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      if (k == 9) req_valid = 1'b0;
      if (rsp_valid) begin
        rsp_mask |= (1 << (k - 1));
        if (req_ready) viol++;
        if (rsp_rdata !== ref_mem[0] || rsp_err !== 1'b0) viol++;
      end
      if (!mem_RDn && mem_addr !== 5'd0) viol++;
    end
    check("b2b_rsp_pattern", 32'(rsp_mask), 32'b010010010);
    check("b2b_violations", 32'(viol), 32'd0);
    repeat (3) @(negedge CLK);
    check("b2b_idle_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
